// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic light monitor: phase and fault-code encodings, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: none.
package traffic_light_pkg;

    // Encoding matches the phase output of the monitor.
    typedef enum logic [1:0] {
        PH_NS_GREEN  = 2'b00,
        PH_NS_YELLOW = 2'b01,
        PH_EW_GREEN  = 2'b10,
        PH_EW_YELLOW = 2'b11
    } phase_e;

    // Lower value wins when several violations land on the same sample.
    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_CONFLICT     = 3'd1,
        FC_ILLEGAL      = 3'd2,
        FC_SEQUENCE     = 3'd3,
        FC_YELLOW_SHORT = 3'd4,
        FC_GREEN_SHORT  = 3'd5,
        FC_TIMEOUT      = 3'd6
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } tlm_state_e;

    localparam int CYCLE_CNT_W = 16;

    // The only legal successor of each phase; the cycle is closed (EWY -> NSG).
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_NS_GREEN:  n = PH_NS_YELLOW;
            PH_NS_YELLOW: n = PH_EW_GREEN;
            PH_EW_GREEN:  n = PH_EW_YELLOW;
            default:      n = PH_NS_GREEN;
        endcase
        return n;
    endfunction

    // Yellow phases share the low encoding bit.
    function automatic logic is_yellow(input phase_e p);
        return p[0];
    endfunction

endpackage

// File: rtl/tlm_phase_decoder.sv
// Maps the six observed lamp drives to a phase, a legal flag and a conflict flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the lamps are sampled every cycle by the parent.
module tlm_phase_decoder
    import traffic_light_pkg::*;
(
    input  logic   ns_red_i,
    input  logic   ns_yellow_i,
    input  logic   ns_green_i,
    input  logic   ew_red_i,
    input  logic   ew_yellow_i,
    input  logic   ew_green_i,
    output phase_e phase_o,
    output logic   legal_o,
    output logic   conflict_o
);

    logic ns_go;
    logic ew_go;
    logic ns_red_only;
    logic ew_red_only;

    // Conflict: some direction is being let through while neither direction is
    // cleanly held at red. This also covers green/yellow on both directions at
    // once. A fully dark intersection has nothing let through, so it is left to
    // the illegal-encoding class rather than flagged here.
    always_comb begin
        ns_go       = ns_yellow_i | ns_green_i;
        ew_go       = ew_yellow_i | ew_green_i;
        ns_red_only = ns_red_i & ~ns_go;
        ew_red_only = ew_red_i & ~ew_go;
        conflict_o  = (ns_go | ew_go) & ~ns_red_only & ~ew_red_only;
    end

    // Exactly four lamp patterns are legal; everything else is reported illegal.
    always_comb begin
        phase_o = PH_NS_GREEN;
        legal_o = 1'b0;
        case ({ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i})
            6'b001_100: begin phase_o = PH_NS_GREEN;  legal_o = 1'b1; end
            6'b010_100: begin phase_o = PH_NS_YELLOW; legal_o = 1'b1; end
            6'b100_001: begin phase_o = PH_EW_GREEN;  legal_o = 1'b1; end
            6'b100_010: begin phase_o = PH_EW_YELLOW; legal_o = 1'b1; end
            default:    begin phase_o = PH_NS_GREEN;  legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches lamp drives, tracks the legal phase sequence and dwell times, latches the first fault (flash request).
// Latency: every decision is visible on the outputs one clk after the triggering lamp sample.
// Backpressure: none; lamps sampled every cycle. Optional cycle counter built only with TLM_CYCLE_COUNT_EN.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_GREEN  = 5,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_PHASE  = 31,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ns_red,
    input  logic                   ns_yellow,
    input  logic                   ns_green,
    input  logic                   ew_red,
    input  logic                   ew_yellow,
    input  logic                   ew_green,
    input  logic                   fault_clr,
    output logic [1:0]             phase,
    output logic                   phase_valid,
    output logic                   fault,
    output logic [2:0]             fault_code,
    output logic [CYCLE_CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PHASE);

    // Decoded view of the current lamp sample.
    phase_e dec_phase;
    logic   dec_legal;
    logic   dec_conflict;

    // Registered state and outputs.
    tlm_state_e       state_q;
    phase_e           phase_q;
    logic             valid_q;
    logic             fault_q;
    fault_code_e      code_q;
    logic [CNT_W-1:0] dwell_q;
    // Set while the phase entered from INIT is still showing: that phase began
    // before monitoring started, so its length is unknown and not min-checked.
    logic             first_q;

    // Classification of this sample against the tracked phase.
    fault_code_e      viol_code;
    logic             same_phase;
    logic             advance;
    logic [CNT_W-1:0] dwell_d;

    tlm_phase_decoder u_decoder (
        .ns_red_i    (ns_red),
        .ns_yellow_i (ns_yellow),
        .ns_green_i  (ns_green),
        .ew_red_i    (ew_red),
        .ew_yellow_i (ew_yellow),
        .ew_green_i  (ew_green),
        .phase_o     (dec_phase),
        .legal_o     (dec_legal),
        .conflict_o  (dec_conflict)
    );

    // Saturating dwell increment for a held pattern.
    always_comb begin
        dwell_d = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + DWELL_ONE;
    end

    // Check the sample; the if/else order encodes lowest-code-wins.
    always_comb begin
        viol_code  = FC_NONE;
        same_phase = 1'b0;
        advance    = 1'b0;
        if (state_q != ST_FAULT) begin
            if (dec_conflict) begin
                viol_code = FC_CONFLICT;
            end else if (!dec_legal) begin
                viol_code = FC_ILLEGAL;
            end else if (state_q == ST_TRACK) begin
                if (dec_phase == phase_q) begin
                    same_phase = 1'b1;
                    // Holding this sample would push the dwell past the limit.
                    if (dwell_q >= MAX_C) begin
                        viol_code = FC_TIMEOUT;
                    end
                end else if (dec_phase != next_phase(phase_q)) begin
                    viol_code = FC_SEQUENCE;
                end else if (!first_q && is_yellow(phase_q) && (dwell_q < MIN_Y_C)) begin
                    viol_code = FC_YELLOW_SHORT;
                end else if (!first_q && !is_yellow(phase_q) && (dwell_q < MIN_G_C)) begin
                    viol_code = FC_GREEN_SHORT;
                end else begin
                    advance = 1'b1;
                end
            end
        end
    end

    // Monitor FSM: INIT waits for a legal pattern, TRACK follows the sequence,
    // FAULT holds the first fault until cleared. Reset outranks everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            phase_q <= PH_NS_GREEN;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            dwell_q <= '0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (viol_code != FC_NONE) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= viol_code;
                        valid_q <= 1'b0;
                    end else begin
                        state_q <= ST_TRACK;
                        phase_q <= dec_phase;
                        valid_q <= 1'b1;
                        dwell_q <= DWELL_ONE;
                        first_q <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (viol_code != FC_NONE) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        code_q  <= viol_code;
                        valid_q <= 1'b0;
                    end else if (same_phase) begin
                        dwell_q <= dwell_d;
                    end else if (advance) begin
                        phase_q <= dec_phase;
                        dwell_q <= DWELL_ONE;
                        first_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    // phase_q keeps the last legal phase while faulted.
                    if (fault_clr) begin
                        state_q <= ST_INIT;
                        fault_q <= 1'b0;
                        code_q  <= FC_NONE;
                        dwell_q <= '0;
                        first_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

`ifdef TLM_CYCLE_COUNT_EN
    logic                   cyc_inc;
    logic [CYCLE_CNT_W-1:0] cyc_q;

    // A full signal cycle completes on an accepted EW_YELLOW -> NS_GREEN step.
    always_comb begin
        cyc_inc = advance && (phase_q == PH_EW_YELLOW);
    end

    // Free-running wrap counter; only reset clears it, faults do not.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (cyc_inc) begin
            cyc_q <= cyc_q + CYCLE_CNT_W'(1);
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic        fault_clr;
    logic [1:0]  phase;
    logic        phase_valid;
    logic        fault;
    logic [2:0]  fault_code;
    logic [15:0] cycle_count;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .MIN_GREEN  (5),
        .MIN_YELLOW (2),
        .MAX_PHASE  (31),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ns_red      (ns_red),
        .ns_yellow   (ns_yellow),
        .ns_green    (ns_green),
        .ew_red      (ew_red),
        .ew_yellow   (ew_yellow),
        .ew_green    (ew_green),
        .fault_clr   (fault_clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    // Lamp vectors ordered {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}.
    localparam logic [5:0] L_NSG   = 6'b001_100;
    localparam logic [5:0] L_NSY   = 6'b010_100;
    localparam logic [5:0] L_EWG   = 6'b100_001;
    localparam logic [5:0] L_EWY   = 6'b100_010;
    localparam logic [5:0] L_CONF  = 6'b001_001;
    localparam logic [5:0] L_DARK  = 6'b000_000;
    localparam logic [5:0] L_NS2   = 6'b011_100;
    localparam logic [5:0] L_NSOFF = 6'b000_100;
    localparam logic [5:0] L_NSGO  = 6'b001_000;

`ifdef TLM_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    function automatic logic [15:0] cc_exp(input int n);
        return CC_EN ? 16'(n) : 16'd0;
    endfunction

    typedef struct {
        logic [5:0] lamps;
        logic       clr;
        logic       rst;
        int         n;
        logic [6:0] exp;   // {phase, phase_valid, fault, fault_code}
    } step_t;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q[$];
    step_t      plan[$];
    logic [6:0] got;
    logic [6:0] want;

    task automatic add(input logic [5:0] l, input logic clr, input logic rst, input int n,
                       input logic [1:0] ph, input logic v, input logic f, input logic [2:0] c);
        step_t s;
        s.lamps = l; s.clr = clr; s.rst = rst; s.n = n; s.exp = {ph, v, f, c};
        plan.push_back(s);
    endtask

    // Apply one sample, queue its expected outcome, land 1 unit after the edge.
    task automatic drive(input logic [5:0] l, input logic clr, input logic rst, input logic [6:0] e);
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = l;
        fault_clr = clr;
        reset     = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        plan.delete();
        add(L_CONF, 1'b1, 1'b1, 2, 2'b00, 1'b0, 1'b0, 3'd0);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL reset[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== 16'd0) begin bad++; $display("FAIL reset_cycle_count: got %0d want 0", cycle_count); end
    endtask

    task automatic test_legal_loop();
        plan.delete();
        for (int k = 0; k < 3; k++) begin
            add(L_NSG, 1'b0, 1'b0, 6, 2'b00, 1'b1, 1'b0, 3'd0);
            add(L_NSY, 1'b0, 1'b0, 3, 2'b01, 1'b1, 1'b0, 3'd0);
            add(L_EWG, 1'b0, 1'b0, 6, 2'b10, 1'b1, 1'b0, 3'd0);
            add(L_EWY, 1'b0, 1'b0, 3, 2'b11, 1'b1, 1'b0, 3'd0);
        end
        add(L_NSG, 1'b0, 1'b0, 1, 2'b00, 1'b1, 1'b0, 3'd0);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL legal_loop[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== cc_exp(3)) begin bad++; $display("FAIL legal_loop_cycle_count: got %0d want %0d", cycle_count, cc_exp(3)); end
    endtask

    // Continues from the legal loop: conflict, held fault, clear, resume.
    task automatic test_conflict_clear();
        plan.delete();
        add(L_NSG,  1'b0, 1'b0, 2, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_CONF, 1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd1);
        add(L_NSG,  1'b0, 1'b0, 2, 2'b00, 1'b0, 1'b1, 3'd1);
        add(L_EWG,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd1);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL conflict[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== cc_exp(3)) begin bad++; $display("FAIL conflict_cycle_hold: got %0d want %0d", cycle_count, cc_exp(3)); end
        plan.delete();
        add(L_NSG, 1'b1, 1'b0, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NSG, 1'b0, 1'b0, 2, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSY, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0, 3'd0);
        add(L_EWG, 1'b0, 1'b0, 5, 2'b10, 1'b1, 1'b0, 3'd0);
        add(L_EWY, 1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG, 1'b0, 1'b0, 1, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSG, 1'b1, 1'b0, 1, 2'b00, 1'b1, 1'b0, 3'd0);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL clear_resume[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== cc_exp(4)) begin bad++; $display("FAIL clear_cycle_count: got %0d want %0d", cycle_count, cc_exp(4)); end
    endtask

    // Skip, plus a skip that is also too short: lowest code (3) must win.
    task automatic test_sequence_skip();
        plan.delete();
        add(L_DARK, 1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_EWY,  1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 6, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_EWG,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd3);
        add(L_DARK, 1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_EWY,  1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 2, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_EWG,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd3);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL sequence_skip[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
    endtask

    task automatic test_dwell_minimums();
        plan.delete();
        // Short yellow.
        add(L_DARK, 1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_EWY,  1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 6, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSY,  1'b0, 1'b0, 1, 2'b01, 1'b1, 1'b0, 3'd0);
        add(L_EWG,  1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b1, 3'd4);
        // Exactly-minimum dwells are legal, then a 4-cycle green is short.
        add(L_DARK, 1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_EWY,  1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 5, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSY,  1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0, 3'd0);
        add(L_EWG,  1'b0, 1'b0, 5, 2'b10, 1'b1, 1'b0, 3'd0);
        add(L_EWY,  1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 4, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSY,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd5);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL dwell_min[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== cc_exp(2)) begin bad++; $display("FAIL dwell_min_cycle_count: got %0d want %0d", cycle_count, cc_exp(2)); end
    endtask

    task automatic test_timeout();
        plan.delete();
        add(L_DARK, 1'b0, 1'b1, 1,  2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 31, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 2,  2'b00, 1'b0, 1'b1, 3'd6);
        add(L_CONF, 1'b0, 1'b0, 1,  2'b00, 1'b0, 1'b1, 3'd6);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL timeout[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
    endtask

    // Entered while faulted from the timeout test.
    task automatic test_reset_priority();
        plan.delete();
        add(L_CONF, 1'b1, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 3, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_CONF, 1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NSG,  1'b0, 1'b0, 2, 2'b00, 1'b1, 1'b0, 3'd0);
        add(L_NSY,  1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0, 3'd0);
        add(L_EWG,  1'b0, 1'b0, 1, 2'b10, 1'b1, 1'b0, 3'd0);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL reset_priority[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
        total++;
        if (cycle_count !== 16'd0) begin bad++; $display("FAIL reset_priority_cycle_count: got %0d want 0", cycle_count); end
    endtask

    task automatic test_illegal();
        plan.delete();
        add(L_DARK,  1'b0, 1'b1, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_DARK,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd2);
        add(L_DARK,  1'b1, 1'b0, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NS2,   1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd2);
        add(L_DARK,  1'b1, 1'b0, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_NSGO,  1'b0, 1'b0, 1, 2'b00, 1'b0, 1'b1, 3'd1);
        add(L_DARK,  1'b1, 1'b0, 1, 2'b00, 1'b0, 1'b0, 3'd0);
        add(L_EWY,   1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0, 3'd0);
        add(L_NSOFF, 1'b0, 1'b0, 1, 2'b11, 1'b0, 1'b1, 3'd2);
        foreach (plan[i]) for (int r = 0; r < plan[i].n; r++) begin
            drive(plan[i].lamps, plan[i].clr, plan[i].rst, plan[i].exp);
            got = {phase, phase_valid, fault, fault_code}; want = exp_q.pop_front(); total++;
            if (got !== want) begin bad++; $display("FAIL illegal[%0d.%0d]: got {ph,vld,flt,code}=%b want %b", i, r, got, want); end
        end
    endtask

    initial begin
        reset = 1'b1;
        fault_clr = 1'b0;
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = 6'd0;
        test_reset();
        test_legal_loop();
        test_conflict_clear();
        test_sequence_skip();
        test_dwell_minimums();
        test_timeout();
        test_reset_priority();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
